// File: rtl/bus_wait_decoder.sv
// Address decoder and wait-state generator for the 8-bit CPU bus.
// Each memory region and the I/O space stall the CPU for a fixed number of clocks.
//
// state  | meaning
// IDLE   | no cycle in progress; wait count sampled live from the current request
// WAIT   | counting down remaining wait clocks, buswait_n held low
// DONE   | wait satisfied, holding until the CPU drops the request
module bus_wait_decoder #(
    parameter int ADDR_WIDTH = 16,
    parameter int SEL_BITS   = 1,
    parameter int WAIT_WIDTH = 4,
    parameter logic [(2**SEL_BITS)*WAIT_WIDTH-1:0] MEM_WAITS = '0,
    parameter logic [WAIT_WIDTH-1:0] IO_WAITS = WAIT_WIDTH'(1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mreq_n,
    input  logic                    iorq_n,
    input  logic                    rd_n,
    input  logic                    wr_n,
    input  logic [ADDR_WIDTH-1:0]   addr,
    output logic [(2**SEL_BITS)-1:0] mem_en_n,
    output logic                    io_en_n,
    output logic                    buswait_n,
    output logic                    bus_err
);
    localparam int N_REGIONS = 2**SEL_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [WAIT_WIDTH-1:0] cnt, cnt_nxt;
    logic [SEL_BITS-1:0]   region;
    logic [WAIT_WIDTH-1:0] w_mem, w_live;
    logic                  mem_sel, conflict, conflict_q, req, abort, wait_low;
    logic                  unused_addr;

    assign region      = addr[ADDR_WIDTH-1 -: SEL_BITS];
    assign unused_addr = ^addr[ADDR_WIDTH-SEL_BITS-1:0];
    assign mem_sel     = ~mreq_n & iorq_n;
    assign io_en_n     = ~(~iorq_n & mreq_n);
    assign conflict    = ~mreq_n & ~iorq_n;
    assign req         = (~mreq_n ^ ~iorq_n) & (~rd_n | ~wr_n);

    always_comb begin
        mem_en_n = '1;
        w_mem    = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (region == SEL_BITS'(i)) begin
                w_mem       = MEM_WAITS[i*WAIT_WIDTH +: WAIT_WIDTH];
                mem_en_n[i] = ~mem_sel;
            end
        end
    end

    assign w_live = (~mreq_n) ? w_mem : IO_WAITS;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (w_live > WAIT_WIDTH'(1)) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = w_live - WAIT_WIDTH'(1);
                    end else begin
                        state_nxt = ST_DONE;
                        cnt_nxt   = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    abort     = 1'b1;
                end else begin
                    cnt_nxt = cnt - WAIT_WIDTH'(1);
                    if (cnt == WAIT_WIDTH'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pre-assert in IDLE so the CPU sees the stall in the very first cycle.
    assign wait_low  = ((state == ST_IDLE) & req & (w_live != '0)) | (state == ST_WAIT);
    assign buswait_n = ~reset_n | ~wait_low;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            conflict_q <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            conflict_q <= conflict;
            bus_err    <= (conflict & ~conflict_q) | abort;
        end
    end
endmodule
